// File: rtl/loader_pkg.sv
// Shared definitions for the host program loader: FSM states, frame marker, cmd field positions.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // cmd byte layout: {start_addr, len_m1}
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 4;
  localparam int CMD_LEN_MSB  = 3;
  localparam int CMD_LEN_LSB  = 0;

endpackage

// File: rtl/program_loader.sv
// Host byte-stream loader for the SAP CPU program RAM; writes each data byte one cycle after acceptance,
// holds the CPU in reset during a frame and releases it only when the XOR checksum verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W    = 4,
  parameter int          DATA_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = loader_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              load_mode,
  output logic [ADDR_W-1:0] load_address,
  output logic [DATA_W-1:0] load_program,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_ptr_q, addr_ptr_d;
  logic [3:0]         remaining_q, remaining_d;
  logic [7:0]         acc_q, acc_d;
  logic               match_q, match_d;
  logic               load_mode_q, load_mode_d;
  logic [ADDR_W-1:0]  load_address_q, load_address_d;
  logic [DATA_W-1:0]  load_program_q, load_program_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               accept;

  assign in_ready = (state_q != S_FINISH);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d        = state_q;
    addr_ptr_d     = addr_ptr_q;
    remaining_d    = remaining_q;
    acc_d          = acc_q;
    match_d        = match_q;
    load_mode_d    = 1'b0;
    load_address_d = load_address_q;
    load_program_d = load_program_q;
    cpu_reset_d    = cpu_reset_q;
    busy_d         = busy_q;
    err_d          = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d     = S_CMD;
          busy_d      = 1'b1;
          cpu_reset_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      S_CMD: begin
        if (accept) begin
          addr_ptr_d  = ADDR_W'(in_data[CMD_ADDR_MSB:CMD_ADDR_LSB]);
          remaining_d = in_data[CMD_LEN_MSB:CMD_LEN_LSB];
          acc_d       = in_data;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          load_mode_d    = 1'b1;
          load_address_d = addr_ptr_q;
          load_program_d = DATA_W'(in_data);
          addr_ptr_d     = addr_ptr_q + 1'b1;
          acc_d          = acc_q ^ in_data;
          remaining_d    = remaining_q - 4'd1;
          if (remaining_q == 4'd0) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          match_d = (in_data == acc_q);
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        // A failed frame leaves the CPU held; err stays set until the next SYNC.
        busy_d      = 1'b0;
        cpu_reset_d = match_q;
        err_d       = err_q | ~match_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      addr_ptr_q     <= '0;
      remaining_q    <= '0;
      acc_q          <= '0;
      match_q        <= 1'b0;
      load_mode_q    <= 1'b0;
      load_address_q <= '0;
      load_program_q <= '0;
      cpu_reset_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_ptr_q     <= addr_ptr_d;
      remaining_q    <= remaining_d;
      acc_q          <= acc_d;
      match_q        <= match_d;
      load_mode_q    <= load_mode_d;
      load_address_q <= load_address_d;
      load_program_q <= load_program_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign load_mode    = load_mode_q;
  assign load_address = load_address_q;
  assign load_program = load_program_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign done         = (state_q == S_FINISH) && match_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame-level reference model checked every cycle, plus literal RAM/flag checks.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, load_mode, cpu_reset, busy, done, err;
  logic [3:0] load_address;
  logic [7:0] load_program;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_mode(load_mode), .load_address(load_address), .load_program(load_program),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame bytes after SYNC are kept in a list and outputs derived from frame position.
  bit         started = 0;
  bit         in_frame = 0, fin = 0, fin_ok = 0;
  logic [7:0] frame[$];
  logic       e_ready = 1, e_mode = 0, e_cpu = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [3:0] e_addr = 0;
  logic [7:0] e_prog = 0;

  always @(posedge clk) begin
    int n, len;
    logic [7:0] x;
    started = 1;
    e_mode = 0;
    e_done = 0;
    if (!reset) begin
      in_frame = 0; fin = 0; frame.delete();
      e_ready = 1; e_addr = 0; e_prog = 0; e_cpu = 0; e_busy = 0; e_err = 0;
    end else if (fin) begin
      fin = 0; e_ready = 1; e_busy = 0;
      if (fin_ok) e_cpu = 1; else e_err = 1;
    end else if (in_valid && e_ready) begin
      if (!in_frame) begin
        if (in_data == 8'hA5) begin
          in_frame = 1; frame.delete(); e_busy = 1; e_cpu = 0; e_err = 0;
        end
      end else begin
        frame.push_back(in_data);
        n = frame.size();
        len = int'(frame[0][3:0]) + 1;
        if (n >= 2 && n <= len + 1) begin
          e_mode = 1;
          e_addr = 4'((int'(frame[0][7:4]) + n - 2) % 16);
          e_prog = in_data;
        end
        if (n == len + 2) begin
          x = 8'h00;
          for (int i = 0; i < n - 1; i++) x ^= frame[i];
          fin_ok = (in_data == x);
          fin = 1; in_frame = 0; e_ready = 0; e_done = fin_ok;
        end
      end
    end
  end

  // Per-cycle compare plus a RAM image and event counters built from the DUT's write port.
  logic [7:0] ram [16];
  int strobes = 0, dones = 0;

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", 32'(in_ready), 32'(e_ready));
      check("load_mode", 32'(load_mode), 32'(e_mode));
      check("load_address", 32'(load_address), 32'(e_addr));
      check("load_program", 32'(load_program), 32'(e_prog));
      check("cpu_reset", 32'(cpu_reset), 32'(e_cpu));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(e_err));
      if (load_mode === 1'b1) begin
        ram[load_address] = load_program;
        strobes++;
      end
      if (done === 1'b1) dones++;
    end
  end

  task automatic send(input logic [7:0] b);
    logic rdy;
    bit ok = 0;
    in_valid = 1; in_data = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) ok = 1;
    end
    in_valid = 0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL send_timeout: byte %h not accepted, expected acceptance within 20 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 0; in_valid = 0;
    repeat (n) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic send_basic();
    send(8'hA5); send(8'h04); send(8'h79); send(8'h30);
    send(8'h7A); send(8'h10); send(8'h40); send(8'h67);
  endtask

  initial begin
    int s0, d0;
    logic [7:0] c;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    do_reset(2);
    check("reset_cpu_reset", 32'(cpu_reset), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);

    // Basic load
    s0 = strobes; d0 = dones;
    send_basic(); idle(3);
    check("basic_ram0", 32'(ram[0]), 32'h79);
    check("basic_ram1", 32'(ram[1]), 32'h30);
    check("basic_ram2", 32'(ram[2]), 32'h7A);
    check("basic_ram3", 32'(ram[3]), 32'h10);
    check("basic_ram4", 32'(ram[4]), 32'h40);
    check("basic_strobes", 32'(strobes - s0), 32'd5);
    check("basic_dones", 32'(dones - d0), 32'd1);
    check("basic_cpu_run", 32'(cpu_reset), 32'h1);

    // Wrap-around F -> 0
    send(8'hA5); send(8'hF1); send(8'h08); send(8'h0B); send(8'hF2); idle(3);
    check("wrap_ramF", 32'(ram[15]), 32'h08);
    check("wrap_ram0", 32'(ram[0]), 32'h0B);

    // Bad checksum, then recovery
    s0 = strobes; d0 = dones;
    send(8'hA5); send(8'h04); send(8'h79); send(8'h30);
    send(8'h7A); send(8'h10); send(8'h40); send(8'h66); idle(4);
    check("bad_strobes", 32'(strobes - s0), 32'd5);
    check("bad_err", 32'(err), 32'h1);
    check("bad_cpu_held", 32'(cpu_reset), 32'h0);
    check("bad_no_done", 32'(dones - d0), 32'd0);
    send_basic(); idle(2);
    check("recover_err", 32'(err), 32'h0);
    check("recover_cpu", 32'(cpu_reset), 32'h1);

    // Junk before SYNC, stalls between data bytes
    s0 = strobes;
    send(8'h00); send(8'hFF); idle(2);
    check("junk_no_strobe", 32'(strobes - s0), 32'd0);
    send(8'hA5); send(8'h32); send(8'h11); idle(3);
    send(8'h22); idle(3); send(8'h33); send(8'h32); idle(3);
    check("stall_ram3", 32'(ram[3]), 32'h11);
    check("stall_ram4", 32'(ram[4]), 32'h22);
    check("stall_ram5", 32'(ram[5]), 32'h33);
    check("stall_strobes", 32'(strobes - s0), 32'd3);

    // Full 16-byte frame
    s0 = strobes;
    c = 8'h0F;
    send(8'hA5); send(8'h0F);
    for (int i = 0; i < 16; i++) begin
      send(8'hC0 + 8'(i));
      c ^= 8'hC0 + 8'(i);
    end
    send(c); idle(3);
    check("full_strobes", 32'(strobes - s0), 32'd16);
    check("full_ram0", 32'(ram[0]), 32'hC0);
    check("full_ram7", 32'(ram[7]), 32'hC7);
    check("full_ramF", 32'(ram[15]), 32'hCF);
    check("full_cpu", 32'(cpu_reset), 32'h1);

    // Reset mid-frame; writes already made stay, leftover bytes are ignored
    send(8'hA5); send(8'h04); send(8'h55); send(8'h66);
    do_reset(1);
    check("midrst_cpu", 32'(cpu_reset), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_addr", 32'(load_address), 32'h0);
    check("midrst_ram0", 32'(ram[0]), 32'h55);
    check("midrst_ram1", 32'(ram[1]), 32'h66);
    s0 = strobes;
    send(8'h7A); send(8'h10); send(8'h40); send(8'h67); idle(2);
    check("midrst_ignored", 32'(strobes - s0), 32'd0);
    send_basic(); idle(2);
    check("midrst_reload_cpu", 32'(cpu_reset), 32'h1);
    check("midrst_reload_ram0", 32'(ram[0]), 32'h79);

    // Reload while running
    send(8'hA5);
    check("reload_cpu_held", 32'(cpu_reset), 32'h0);
    check("reload_busy", 32'(busy), 32'h1);
    send(8'h04); send(8'h79); send(8'h30); send(8'h7A);
    send(8'h10); send(8'h40); send(8'h67); idle(2);
    check("reload_cpu_run", 32'(cpu_reset), 32'h1);
    check("reload_busy_end", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Host-side load port for the 4-bit SAP-style CPU.
- Accepts a framed byte stream from a host over a valid/ready handshake and writes each data byte into program RAM through the RAM's load interface (mode, address, program byte).
- Holds the CPU in reset while a frame is in progress and releases it only after the frame checksum verifies.
- Is the responder to the host initiator and the writer for the RAM's load port. It replaces bench-driven RAM preloading.

Parameters:
- ADDR_W, 4: RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8: program byte width.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte this cycle.
- load_mode  out  1  RAM write strobe, one cycle per data byte; drives the RAM input_mode.
- load_address  out  ADDR_W  RAM write address; drives the RAM input_address.
- load_program  out  DATA_W  RAM write data; drives the RAM input_program.
- cpu_reset  out  1  active-low reset to the CPU: 0 holds the CPU, 1 lets it run.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame verifies.
- err  out  1  sticky checksum-error flag.

Behaviour:
- Byte acceptance:
  - A byte is accepted on a rising edge where in_valid and in_ready are both 1.
  - in_ready is 1 in every state except FINISH.
- Frame format:
  - SYNC_BYTE.
  - cmd = {start_addr[3:0], len_m1[3:0]}, giving 1..16 data bytes.
  - len_m1+1 data bytes.
  - chk = XOR of cmd and all data bytes.
- State IDLE:
  - Any byte other than SYNC_BYTE is discarded with no other effect.
  - Accepting SYNC_BYTE moves to CMD. On the following edge busy goes 1, cpu_reset goes 0 and err is cleared.
- State CMD:
  - Accepting cmd latches addr_ptr = start_addr, remaining = len_m1 and acc = cmd, then moves to DATA.
- State DATA:
  - Each accepted byte d causes, in the next cycle: load_mode=1, load_address=addr_ptr, load_program=d.
  - Per accepted byte: addr_ptr increments with wrap (F->0); acc ^= d; remaining decrements.
  - The byte accepted while remaining==0 moves the FSM to CHK.
  - Latency from acceptance to the write strobe is exactly 1 cycle.
- State CHK:
  - Accepting byte c moves to FINISH and latches match = (c==acc).
- State FINISH (1 cycle, in_ready=0):
  - If match: done=1 this cycle; cpu_reset=1 and busy=0 from the next cycle.
  - Otherwise: err=1 (sticky); cpu_reset stays 0; busy=0.
  - Returns to IDLE.
- Output hold rules:
  - load_mode is 0 in every cycle other than the strobe cycle.
  - load_address and load_program hold their last values between strobes.
- Host stalls: in_valid low between bytes simply waits in the current state. There is no timeout.
- Reload: SYNC_BYTE arriving in IDLE while the CPU is running starts a new frame and re-asserts the CPU hold, i.e. cpu_reset=0 on the next cycle.
- A SYNC_BYTE value inside CMD/DATA/CHK is treated as ordinary data. There is no resync mid-frame.
- Reset values (including when reset is asserted mid-frame; the partial frame is abandoned and RAM writes already made stay):
  - state=IDLE, in_ready=1, load_mode=0, load_address=0, load_program=0.
  - cpu_reset=0, busy=0, done=0, err=0.
  - After reset the CPU stays held until the first verified frame.

Decomposition:
- Shared package loader_pkg: state enum (IDLE, CMD, DATA, CHK, FINISH), SYNC_BYTE, and the cmd field slice constants.
- A single module is natural. Checksum and address pointer stay inline; no sub-module.

Test Plan:
- Basic load: reset low 2 cycles, then stream A5,04,79,30,7A,10,40,67 -> strobes write addr0..4 = 79,30,7A,10,40, each 1 cycle after acceptance; done pulses once; cpu_reset rises the cycle after done; err=0.
- Wrap-around: stream A5,F1,08,0B,F2 -> writes addr F=08 then addr 0=0B; done=1.
- Bad checksum: A5,04,79,30,7A,10,40,66 -> the 5 writes occur; err=1 and sticky; cpu_reset stays 0. A following good frame clears err and ends with done.
- Framing and stalls: 00,FF before A5 are discarded with no strobe. in_valid toggled off for 3 cycles between data bytes gives no duplicate strobes and addresses stay correct. A 16-byte frame (cmd 0x0F) writes all addresses 0..F.
- Reset mid-frame: assert reset after the 2nd data byte -> all outputs at reset values next cycle, cpu_reset=0. The remaining host bytes are ignored until A5; a full frame afterwards succeeds.
- Reload while running: after a good load, send A5 -> cpu_reset=0 and busy=1 on the next cycle; a complete frame restores cpu_reset=1.
